// File: rtl/logic_gate_tt_sequencer_if.sv
// Bundle between the truth-table sequencer and its gate unit / status logic.
// The sequencer is the master: it drives gate_a/gate_b and the result fields.
interface logic_gate_tt_sequencer_if;
  logic        start;
  logic [7:0]  gate_res;
  logic        gate_a;
  logic        gate_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_mask;
  logic [31:0] tt_out;

  modport master (
    input  start, gate_res,
    output gate_a, gate_b, busy, done, pass, fail_mask, tt_out
  );

  modport slave (
    output start, gate_res,
    input  gate_a, gate_b, busy, done, pass, fail_mask, tt_out
  );
endinterface

// File: rtl/logic_gate_tt_sequencer.sv
// Self-test sequencer: walks a/b through 00,01,10,11, samples the gate outputs and checks them.
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatching row.
module logic_gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                        clk,
  input logic                        rst,
  logic_gate_tt_sequencer_if.master  bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrive  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StSample = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [31:0] GoldenTable = 32'h835A56BC;
  localparam logic [3:0]  SettleLast  = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gate_a_q, gate_a_d;
  logic        gate_b_q, gate_b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_mask_q, fail_mask_d;
  logic [31:0] tt_q, tt_d;

  logic [7:0]  row_golden;
  logic        row_mismatch;

  always_comb begin
    row_golden   = GoldenTable[{idx_q, 3'b000} +: 8];
    row_mismatch = (bus.gate_res != row_golden);

    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    tt_d        = tt_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StDrive;
          idx_d       = 2'd0;
          tt_d        = 32'd0;
          fail_mask_d = 4'd0;
          pass_d      = 1'b0;
        end
      end
      StDrive: begin
        gate_a_d = idx_q[1];
        gate_b_d = idx_q[0];
        cnt_d    = 4'd0;
        state_d  = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        tt_d[{idx_q, 3'b000} +: 8] = bus.gate_res;
        fail_mask_d[idx_q]         = row_mismatch;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        if (row_mismatch || (idx_q == 2'd3)) begin
`else
        if (idx_q == 2'd3) begin
`endif
          state_d = StDone;
          done_d  = 1'b1;
          // Uses the next-state mask so a mismatch on the final row still clears pass.
          pass_d  = (fail_mask_d == 4'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
      tt_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      tt_q        <= tt_d;
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.tt_out    = tt_q;

endmodule

// File: tb/tb_logic_gate_tt_sequencer.sv
// Directed bench for logic_gate_tt_sequencer with a behavioural gate unit model.
// Three instances cover settle times of 1 (main), 0 and 3.
module tb_logic_gate_tt_sequencer;

  logic clk;
  logic rst;
  logic xor_stuck;

  int checks;
  int errors;
  int cyc;
  int done_cnt, done_at;
  int done0_cnt, done0_at;
  int done3_cnt, done3_at;
  logic [7:0] gate_seq;
  logic [3:0] exp_mask;
  logic [31:0] exp_tt;
  int exp_done;

  logic_gate_tt_sequencer_if bus ();
  logic_gate_tt_sequencer_if bus0 ();
  logic_gate_tt_sequencer_if bus3 ();

  function automatic logic [7:0] gate_model(input logic a, input logic b, input logic stuck);
    return {~(a ^ b), (a ^ b) & ~stuck, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
  endfunction

  assign bus.gate_res  = gate_model(bus.gate_a, bus.gate_b, xor_stuck);
  assign bus0.gate_res = gate_model(bus0.gate_a, bus0.gate_b, xor_stuck);
  assign bus3.gate_res = gate_model(bus3.gate_a, bus3.gate_b, xor_stuck);

  logic_gate_tt_sequencer #(.SETTLE_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic_gate_tt_sequencer #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  logic_gate_tt_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done)  begin done_cnt++;  done_at  = cyc; end
    if (bus0.done) begin done0_cnt++; done0_at = cyc; end
    if (bus3.done) begin done3_cnt++; done3_at = cyc; end
    if (cyc == 3 || cyc == 6 || cyc == 9 || cyc == 12)
      gate_seq = {gate_seq[5:0], bus.gate_a, bus.gate_b};
  endtask

  task automatic clear_track();
    cyc = 0;
    done_cnt = 0;  done_at = -1;
    done0_cnt = 0; done0_at = -1;
    done3_cnt = 0; done3_at = -1;
    gate_seq = 8'h00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    xor_stuck = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus0.start = 1'b0;
    bus3.start = 1'b0;
    clear_track();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_pass", {31'd0, bus.pass}, 32'd0);
    check("rst_gate", {30'd0, bus.gate_a, bus.gate_b}, 32'd0);
    check("rst_mask", {28'd0, bus.fail_mask}, 32'd0);
    check("rst_tt", bus.tt_out, 32'd0);

    // Scenario 1: good gate unit, settle 1
    clear_track();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s1_busy_c1", {31'd0, bus.busy}, 32'd1);
    while (cyc < 12) tick();
    check("s1_nodone_c12", {31'd0, bus.done}, 32'd0);
    tick();
    check("s1_done_c13", {31'd0, bus.done}, 32'd1);
    check("s1_busy_c13", {31'd0, bus.busy}, 32'd1);
    check("s1_tt", bus.tt_out, 32'h835A56BC);
    check("s1_pass", {31'd0, bus.pass}, 32'd1);
    check("s1_mask", {28'd0, bus.fail_mask}, 32'd0);
    check("s1_gate_seq", {24'd0, gate_seq}, 32'h0000001B);
    tick();
    check("s1_done_c14", {31'd0, bus.done}, 32'd0);
    check("s1_busy_c14", {31'd0, bus.busy}, 32'd0);
    check("s1_gate_hold", {30'd0, bus.gate_a, bus.gate_b}, 32'd3);
    check("s1_pass_hold", {31'd0, bus.pass}, 32'd1);

    // Scenario 2: xor output stuck at 0
    xor_stuck = 1'b1;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    exp_done = 7;
    exp_mask = 4'b0010;
    exp_tt   = 32'h000016BC;
`else
    exp_done = 13;
    exp_mask = 4'b0110;
    exp_tt   = 32'h831A16BC;
`endif
    clear_track();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < 14) tick();
    check("s2_done_at", done_at, exp_done);
    check("s2_done_cnt", done_cnt, 32'd1);
    check("s2_tt", bus.tt_out, exp_tt);
    check("s2_mask", {28'd0, bus.fail_mask}, {28'd0, exp_mask});
    check("s2_pass", {31'd0, bus.pass}, 32'd0);
    check("s2_busy", {31'd0, bus.busy}, 32'd0);
    xor_stuck = 1'b0;

    // Scenario 3: settle 0 and settle 3
    clear_track();
    bus0.start = 1'b1;
    bus3.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus3.start = 1'b0;
    while (cyc < 22) tick();
    check("s3_done0_at", done0_at, 32'd9);
    check("s3_done3_at", done3_at, 32'd21);
    check("s3_done0_cnt", done0_cnt, 32'd1);
    check("s3_done3_cnt", done3_cnt, 32'd1);
    check("s3_tt0", bus0.tt_out, 32'h835A56BC);
    check("s3_tt3", bus3.tt_out, 32'h835A56BC);
    check("s3_pass0", {31'd0, bus0.pass}, 32'd1);
    check("s3_pass3", {31'd0, bus3.pass}, 32'd1);
    check("s3_mask3", {28'd0, bus3.fail_mask}, 32'd0);

    // Scenario 4: start while busy (cycle 4 and the DONE cycle) is ignored
    clear_track();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < 4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < 13) tick();
    check("s4_done_c13", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s4_idle_c14", {31'd0, bus.busy}, 32'd0);
    check("s4_one_done", done_cnt, 32'd1);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s4_restart_busy", {31'd0, bus.busy}, 32'd1);
    check("s4_restart_tt", bus.tt_out, 32'd0);
    check("s4_restart_pass", {31'd0, bus.pass}, 32'd0);
    while (cyc < 29) tick();
    check("s4_done_cnt", done_cnt, 32'd2);
    check("s4_done_at", done_at, 32'd28);
    check("s4_tt", bus.tt_out, 32'h835A56BC);
    check("s4_pass", {31'd0, bus.pass}, 32'd1);

    // Scenario 5: reset mid-run aborts it
    clear_track();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < 6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_busy", {31'd0, bus.busy}, 32'd0);
    check("s5_tt", bus.tt_out, 32'd0);
    check("s5_gate", {30'd0, bus.gate_a, bus.gate_b}, 32'd0);
    check("s5_pass", {31'd0, bus.pass}, 32'd0);
    while (cyc < 20) tick();
    check("s5_no_done", done_cnt, 32'd0);
    clear_track();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < 14) tick();
    check("s5_rerun_done_at", done_at, 32'd13);
    check("s5_rerun_tt", bus.tt_out, 32'h835A56BC);
    check("s5_rerun_pass", {31'd0, bus.pass}, 32'd1);

    // Scenario 6: reset and start together, reset wins
    clear_track();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    check("s6_busy_c1", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    check("s6_busy_c3", {31'd0, bus.busy}, 32'd0);
    check("s6_tt", bus.tt_out, 32'd0);
    check("s6_no_done", done_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_tt_sequencer.md
Name: logic_gate_tt_sequencer

Overview:
Self-test sequencer for the two-input logic gate unit. On a start pulse it drives the unit's a/b inputs through all four combinations and waits a programmable settle time. It then samples the eight gate outputs, builds a 32-bit truth table and checks each row against the golden values. It sits beside the gate unit as its controller and reports busy/done/pass plus a per-row fail mask to the test or status logic.

Parameters:
SETTLE_CYCLES, 1, cycles to wait after driving a/b before sampling (0..15; 0 means sample in the cycle after drive)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to run a sequence; honoured only in IDLE
gate_res  input  8  gate unit outputs: [0]and [1]or [2]not_a [3]not_b [4]nand [5]nor [6]xor [7]xnor
gate_a  output  1  drive to gate unit input a
gate_b  output  1  drive to gate unit input b
busy  output  1  high from the cycle after start is accepted until DONE is left
done  output  1  one-cycle pulse when the sequence completes
pass  output  1  1 = all sampled rows matched; valid when done=1, held until next accepted start
fail_mask  output  4  bit i set if row i mismatched; held like pass
tt_out  output  32  captured truth table, row i in bits [8i+7:8i]; held like pass

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, gate_a=0, gate_b=0, busy=0, done=0, pass=0, fail_mask=0, tt_out=0, row index=0, settle counter=0.
- Row index idx is 2 bits: gate_a=idx[1], gate_b=idx[0].
- Golden rows: idx0=0xBC, idx1=0x56, idx2=0x5A, idx3=0x83. Full table is 0x835A56BC.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold their last results. start=1 -> DRIVE, idx=0, tt_out=0, fail_mask=0, pass=0, busy=1.
- DRIVE (1 cycle): gate_a/gate_b registered from idx. Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0. The settle counter loads 0.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (1 cycle): tt_out[8idx+:8] <= gate_res. fail_mask[idx] <= (gate_res != golden[idx]). If idx==3 -> DONE, else idx+1 -> DRIVE.
- DONE (1 cycle): done=1 and pass = (fail_mask==0), including any row-3 mismatch from the previous cycle. Next cycle returns to IDLE with busy=0, done=0.
- Latency: start sampled high at edge T gives done=1 during cycle T+1+4*(SETTLE_CYCLES+2). With SETTLE_CYCLES=1 that is T+13.
- gate_a/gate_b keep their last driven value (1,1) after a full run until the next run or reset.
- start while busy, including in the DONE cycle, is ignored. There is no queuing.
- Reset mid-sequence aborts the run. All outputs return to reset values at that edge, and no done pulse is produced.
- rst and start high in the same cycle: reset wins.
- gate_res is sampled only in SAMPLE and is don't-care otherwise.

Optional Feature:
Macro GATE_SEQ_STOP_ON_FAIL_EN.
- Defined: in SAMPLE, a mismatch on row idx goes directly to DONE (pass=0). Rows above idx stay 0 in tt_out and fail_mask, and done arrives early, (idx+1)*(SETTLE_CYCLES+2)+1 cycles after the start edge.
- Undefined: all four rows always run, and fail_mask may have multiple bits set.

Test Plan:
1. Correct gate model, SETTLE_CYCLES=1, start pulse at cycle 0 -> busy=1 from cycle 1, done pulse at cycle 13, tt_out=0x835A56BC, pass=1, fail_mask=0000, gate_a/gate_b sequence 00,01,10,11.
2. Model with xor output stuck at 0 -> tt_out=0x831A16BC, fail_mask=0110, pass=0; with GATE_SEQ_STOP_ON_FAIL_EN, done at cycle 7, fail_mask=0010, tt_out=0x000016BC.
3. SETTLE_CYCLES=0 and SETTLE_CYCLES=3 -> done at cycle 9 and cycle 21 respectively; results identical to scenario 1.
4. start re-asserted at cycles 4 and 13 (the DONE cycle) -> ignored, exactly one done pulse; a new start at cycle 15 runs a fresh sequence with tt_out cleared at acceptance.
5. rst asserted for one cycle at cycle 6 of a run -> next cycle busy=0, tt_out=0, gate_a=gate_b=0, no done pulse; a subsequent start completes normally.
6. rst and start both high in one cycle -> stays IDLE, busy remains 0.
